// File: rtl/rsa_pkg.sv
// Shared types for the RSA exponentiation sequencer: multiplier operand
// selects and sequencer state encoding.
package rsa_pkg;

   localparam int unsigned SEQ_STATE_W = 3;
   localparam int unsigned OPERAND_W   = 3;

   typedef enum logic [OPERAND_W-1:0] {
      OP_M    = 3'd0,
      OP_R2   = 3'd1,
      OP_ONE  = 3'd2,
      OP_MBAR = 3'd3,
      OP_XBAR = 3'd4
   } operand_e;

   typedef enum logic [SEQ_STATE_W-1:0] {
      S_IDLE   = 3'd0,
      S_PRE_M  = 3'd1,
      S_PRE_X  = 3'd2,
      S_SQUARE = 3'd3,
      S_MULT   = 3'd4,
      S_POST   = 3'd5,
      S_DONE   = 3'd6
   } seq_state_e;

endpackage

// File: rtl/rsa_exp_sequencer.sv
// Left-to-right square-and-multiply sequencer driving a shared Montgomery
// multiplier; always walks every exponent bit so run time depends only on popcount.
module rsa_exp_sequencer
   import rsa_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             ena,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] exp_i,
   input  logic             mmm_done,
   output logic             mmm_start,
   output logic             mmm_clr,
   output logic [2:0]       op_a_sel,
   output logic [2:0]       op_b_sel,
   output logic             ld_mbar,
   output logic             ld_xbar,
   output logic             ld_result,
   output logic             busy,
   output logic             eoc
);

   localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   seq_state_e       r_state, w_state_nxt;
   logic [WIDTH-1:0] r_exp_q, w_exp_nxt;
   logic [IDX_W-1:0] r_bit_idx, w_bit_idx_nxt;
   logic             r_issued, w_issued_nxt;

   operand_e         w_op_a, w_op_b;
   logic             w_mmm_start, w_mmm_clr, w_ld_mbar, w_ld_xbar, w_ld_result, w_eoc;

   // State register; ena=0 freezes everything
   always_ff @(posedge clk) begin
      if (!rstb) begin
         r_state   <= S_IDLE;
         r_exp_q   <= '0;
         r_bit_idx <= IDX_W'(WIDTH - 1);
         r_issued  <= 1'b0;
      end else if (ena) begin
         r_state   <= w_state_nxt;
         r_exp_q   <= w_exp_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_issued  <= w_issued_nxt;
      end
   end

   // Next-state and multiplier control
   always_comb begin
      w_state_nxt   = r_state;
      w_exp_nxt     = r_exp_q;
      w_bit_idx_nxt = r_bit_idx;
      w_issued_nxt  = r_issued;
      w_op_a        = OP_M;
      w_op_b        = OP_M;
      w_mmm_start   = 1'b0;
      w_mmm_clr     = 1'b0;
      w_ld_mbar     = 1'b0;
      w_ld_xbar     = 1'b0;
      w_ld_result   = 1'b0;
      w_eoc         = 1'b0;

      case (r_state)
         S_PRE_M:  begin w_op_a = OP_M;    w_op_b = OP_R2;   end
         S_PRE_X:  begin w_op_a = OP_ONE;  w_op_b = OP_R2;   end
         S_SQUARE: begin w_op_a = OP_XBAR; w_op_b = OP_XBAR; end
         S_MULT:   begin w_op_a = OP_MBAR; w_op_b = OP_XBAR; end
         S_POST:   begin w_op_a = OP_XBAR; w_op_b = OP_ONE;  end
         default:  ;
      endcase

      if (r_state == S_IDLE) begin
         if (start && !stop) begin
            w_state_nxt   = S_PRE_M;
            w_exp_nxt     = exp_i;
            w_bit_idx_nxt = IDX_W'(WIDTH - 1);
            w_issued_nxt  = 1'b0;
         end
      end else if (stop) begin
         // Abort wins over a coincident mmm_done
         w_state_nxt  = S_IDLE;
         w_mmm_clr    = 1'b1;
         w_issued_nxt = 1'b0;
      end else if (r_state == S_DONE) begin
         w_eoc       = 1'b1;
         w_state_nxt = S_IDLE;
      end else if (!r_issued) begin
         w_mmm_start  = 1'b1;
         w_issued_nxt = 1'b1;
      end else if (mmm_done) begin
         w_issued_nxt = 1'b0;
         case (r_state)
            S_PRE_M: begin
               w_ld_mbar   = 1'b1;
               w_state_nxt = S_PRE_X;
            end
            S_PRE_X: begin
               w_ld_xbar   = 1'b1;
               w_state_nxt = S_SQUARE;
            end
            S_SQUARE: begin
               w_ld_xbar = 1'b1;
               if (r_exp_q[r_bit_idx]) begin
                  w_state_nxt = S_MULT;
               end else if (r_bit_idx == '0) begin
                  w_state_nxt = S_POST;
               end else begin
                  w_bit_idx_nxt = r_bit_idx - IDX_W'(1);
                  w_state_nxt   = S_SQUARE;
               end
            end
            S_MULT: begin
               w_ld_xbar = 1'b1;
               if (r_bit_idx == '0) begin
                  w_state_nxt = S_POST;
               end else begin
                  w_bit_idx_nxt = r_bit_idx - IDX_W'(1);
                  w_state_nxt   = S_SQUARE;
               end
            end
            S_POST: begin
               w_ld_result = 1'b1;
               w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Pulses are suppressed while the shared enable is low
   assign mmm_start = ena & w_mmm_start;
   assign mmm_clr   = ena & w_mmm_clr;
   assign ld_mbar   = ena & w_ld_mbar;
   assign ld_xbar   = ena & w_ld_xbar;
   assign ld_result = ena & w_ld_result;
   assign eoc       = ena & w_eoc;
   assign busy      = (r_state != S_IDLE);
   assign op_a_sel  = w_op_a;
   assign op_b_sel  = w_op_b;

endmodule

// File: tb/tb_rsa_exp_sequencer.sv
// Bench for rsa_exp_sequencer: multiplier stub with fixed latency, op-sequence
// reference model, table-driven and randomized runs plus abort/reset/enable corners.
module tb_rsa_exp_sequencer;

   localparam int WIDTH = 8;
   localparam int L     = 3;
   // Operand codes and strobe codes used by the reference model
   localparam int C_M = 0, C_R2 = 1, C_ONE = 2, C_MBAR = 3, C_XBAR = 4;
   localparam int LD_MB = 4, LD_XB = 2, LD_RS = 1;

   logic             clk = 1'b0;
   logic             rstb, ena, start, stop, mmm_done;
   logic [WIDTH-1:0] exp_i;
   logic             mmm_start, mmm_clr, ld_mbar, ld_xbar, ld_result, busy, eoc;
   logic [2:0]       op_a_sel, op_b_sel;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit tog    = 1'b0;

   always #5 clk = ~clk;

   rsa_exp_sequencer #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rstb(rstb), .ena(ena), .start(start), .stop(stop),
      .exp_i(exp_i), .mmm_done(mmm_done), .mmm_start(mmm_start),
      .mmm_clr(mmm_clr), .op_a_sel(op_a_sel), .op_b_sel(op_b_sel),
      .ld_mbar(ld_mbar), .ld_xbar(ld_xbar), .ld_result(ld_result),
      .busy(busy), .eoc(eoc)
   );

   // Multiplier stub: done L cycles after launch, frozen while ena=0
   int stub_cnt = 0;
   always @(posedge clk) begin
      if (!rstb) stub_cnt <= 0;
      else if (ena) begin
         if (mmm_clr)             stub_cnt <= 0;
         else if (mmm_start)      stub_cnt <= 1;
         else if (stub_cnt == L)  stub_cnt <= 0;
         else if (stub_cnt != 0)  stub_cnt <= stub_cnt + 1;
      end
   end
   assign mmm_done = (stub_cnt == L);

   always @(posedge clk) cyc <= cyc + 1;

   int ops_q[$];
   int ld_q[$];
   int eoc_cnt = 0, eoc_cyc = 0, clr_cnt = 0, gate_err = 0;

   always @(negedge clk) begin
      if (!ena && (mmm_start || mmm_clr || ld_mbar || ld_xbar || ld_result || eoc))
         gate_err++;
      if (ena && mmm_start) ops_q.push_back(int'(op_a_sel) * 8 + int'(op_b_sel));
      if (ena && (ld_mbar || ld_xbar || ld_result))
         ld_q.push_back(int'({ld_mbar, ld_xbar, ld_result}));
      if (ena && eoc) begin eoc_cnt++; eoc_cyc = cyc; end
      if (ena && mmm_clr) clr_cnt++;
   end

   int model_ops[$];
   int model_lds[$];

   // Square-and-multiply schedule derived straight from the exponent bits
   task automatic build_model(input logic [WIDTH-1:0] e);
      model_ops.delete();
      model_lds.delete();
      model_ops.push_back(C_M * 8 + C_R2);    model_lds.push_back(LD_MB);
      model_ops.push_back(C_ONE * 8 + C_R2);  model_lds.push_back(LD_XB);
      for (int i = WIDTH - 1; i >= 0; i--) begin
         model_ops.push_back(C_XBAR * 8 + C_XBAR); model_lds.push_back(LD_XB);
         if (e[i]) begin
            model_ops.push_back(C_MBAR * 8 + C_XBAR); model_lds.push_back(LD_XB);
         end
      end
      model_ops.push_back(C_XBAR * 8 + C_ONE); model_lds.push_back(LD_RS);
   endtask

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      if (tog) ena = ~ena;
   endtask

   task automatic clear_mon();
      ops_q.delete(); ld_q.delete();
      eoc_cnt = 0; clr_cnt = 0; gate_err = 0;
   endtask

   task automatic run_exp(input string name, input logic [WIDTH-1:0] e,
                          input int n_exp, input int lat_exp, input int poke_at);
      int s;
      int n;
      build_model(e);
      clear_mon();
      step();
      while (!ena) step();
      exp_i = e; start = 1'b1; s = cyc;
      step();
      start = 1'b0; exp_i = ~e;
      for (int i = 0; i < 600 && eoc_cnt == 0; i++) begin
         if (i == poke_at) begin start = 1'b1; exp_i = 8'hFF ^ e; end
         else start = 1'b0;
         step();
      end
      start = 1'b0;
      repeat (6) step();
      chk({name, "_nops"}, ops_q.size(), n_exp);
      chk({name, "_eoc_once"}, eoc_cnt, 1);
      if (lat_exp >= 0) chk({name, "_lat"}, eoc_cyc - s, lat_exp);
      chk({name, "_nld"}, ld_q.size(), model_lds.size());
      n = (ops_q.size() < model_ops.size()) ? ops_q.size() : model_ops.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_op%0d", name, i), ops_q[i], model_ops[i]);
      n = (ld_q.size() < model_lds.size()) ? ld_q.size() : model_lds.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_ld%0d", name, i), ld_q[i], model_lds[i]);
      chk({name, "_gate"}, gate_err, 0);
      chk({name, "_noclr"}, clr_cnt, 0);
   endtask

   typedef struct {
      logic [WIDTH-1:0] e;
      int               n_ops;
      int               lat;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{8'h05, 13, 53};
      vecs[1] = '{8'h00, 11, 45};
      vecs[2] = '{8'hFF, 19, 77};
      vecs[3] = '{8'h80, 12, 49};
      vecs[4] = '{8'h01, 12, 49};

      rstb = 1'b0; ena = 1'b1; start = 1'b0; stop = 1'b0; exp_i = '0;
      repeat (3) step();
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_strobes", int'({mmm_start, mmm_clr, ld_mbar, ld_xbar, ld_result, eoc}), 0);
      chk("rst_sel_a", op_a_sel, C_M);
      chk("rst_sel_b", op_b_sel, C_M);
      step();
      rstb = 1'b1;
      step();

      foreach (vecs[i])
         run_exp($sformatf("vec%0h", vecs[i].e), vecs[i].e, vecs[i].n_ops, vecs[i].lat, -1);

      // Randomized exponents against the model
      for (int k = 0; k < 6; k++) begin
         logic [WIDTH-1:0] e;
         int n;
         e = WIDTH'($urandom);
         build_model(e);
         n = model_ops.size();
         run_exp($sformatf("rnd%0h", e), e, n, 1 + n * (L + 1), -1);
      end

      // start re-pulsed mid-run with another exponent must be ignored
      run_exp("busy_start", 8'h05, 13, 53, 9);

      // Abort during the third SQUARE
      clear_mon();
      step();
      exp_i = 8'h01; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 200 && ops_q.size() < 5; i++) step();
      stop = 1'b1;
      #1;
      chk("stop_clr", mmm_clr, 1);
      chk("stop_busy_before", busy, 1);
      chk("stop_no_ld", int'({ld_mbar, ld_xbar, ld_result, eoc}), 0);
      step();
      stop = 1'b0;
      #1;
      chk("stop_idle", busy, 0);
      chk("stop_clr_gone", mmm_clr, 0);
      repeat (20) step();
      chk("stop_no_eoc", eoc_cnt, 0);
      chk("stop_clr_once", clr_cnt, 1);
      chk("stop_no_more_ops", ops_q.size(), 5);
      run_exp("after_stop", 8'h01, 12, 49, -1);

      // Enable toggled every cycle: same sequence, nothing pulses while low
      tog = 1'b1;
      run_exp("ena_tog", 8'h05, 13, -1, -1);
      tog = 1'b0;
      ena = 1'b1;

      // Synchronous reset in the middle of a MULT
      clear_mon();
      step();
      exp_i = 8'hFF; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 200 && ops_q.size() < 4; i++) step();
      chk("mult_reached", ops_q.size(), 4);
      rstb = 1'b0;
      step();
      @(negedge clk);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_strobes", int'({mmm_start, mmm_clr, ld_mbar, ld_xbar, ld_result, eoc}), 0);
      chk("rstmid_sel", int'({op_a_sel, op_b_sel}), 0);
      step();
      rstb = 1'b1;
      step();
      start = 1'b1; stop = 1'b1; exp_i = 8'h05;
      step();
      step();
      @(negedge clk);
      chk("start_stop_idle", busy, 0);
      chk("start_stop_nostart", mmm_start, 0);
      start = 1'b0; stop = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

endmodule
